// File: rtl/dallanma_ongorucu_if.sv
// Fetch/execute side bundle for the gshare branch predictor.
// master drives lookups and feedback; slave is the predictor itself.
interface dallanma_ongorucu_if #(
  parameter int PS_BIT = 32
) ();
  logic [PS_BIT-1:0] ps_i;
  logic              ps_gecerli_i;
  logic              duraklat_i;
  logic              bosalt_i;
  logic              ongoru_atladi_o;
  logic [PS_BIT-1:0] ongoru_hedef_ps_o;
  logic              ongoru_gecerli_o;
  logic [PS_BIT-1:0] g2_ps_i;
  logic [PS_BIT-1:0] g2_hedef_ps_i;
  logic              g2_guncelle_i;
  logic              g2_atladi_i;
  logic              g2_hatali_tahmin_i;
  logic [31:0]       hatali_sayac_o;

  modport master (
    output ps_i, ps_gecerli_i, duraklat_i, bosalt_i,
    output g2_ps_i, g2_hedef_ps_i, g2_guncelle_i, g2_atladi_i, g2_hatali_tahmin_i,
    input  ongoru_atladi_o, ongoru_hedef_ps_o, ongoru_gecerli_o, hatali_sayac_o
  );

  modport slave (
    input  ps_i, ps_gecerli_i, duraklat_i, bosalt_i,
    input  g2_ps_i, g2_hedef_ps_i, g2_guncelle_i, g2_atladi_i, g2_hatali_tahmin_i,
    output ongoru_atladi_o, ongoru_hedef_ps_o, ongoru_gecerli_o, hatali_sayac_o
  );
endinterface

// File: rtl/dallanma_ongorucu.sv
// Gshare branch predictor: 2-bit counter BHT indexed by PC^GHR plus a
// direct-mapped BTB. Registered 1-cycle lookup, trained by execute feedback.
module dallanma_ongorucu #(
  parameter int PS_BIT    = 32,
  parameter int SATIR_BIT = 5,
  parameter int GGT_BIT   = 5
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  dallanma_ongorucu_if.slave bp
);

  localparam int unsigned SATIR      = 1 << SATIR_BIT;
  localparam int          ETIKET_BIT = PS_BIT - SATIR_BIT - 1;

  logic [1:0]            bht_q        [SATIR];
  logic [1:0]            bht_d        [SATIR];
  logic                  btb_gecerli_q[SATIR];
  logic                  btb_gecerli_d[SATIR];
  logic [ETIKET_BIT-1:0] btb_etiket_q [SATIR];
  logic [ETIKET_BIT-1:0] btb_etiket_d [SATIR];
  logic [PS_BIT-1:0]     btb_hedef_q  [SATIR];
  logic [PS_BIT-1:0]     btb_hedef_d  [SATIR];
  logic [GGT_BIT-1:0]    ghr_q, ghr_d;
  logic [31:0]           sayac_q, sayac_d;
  logic                  atladi_q, atladi_d;
  logic                  gecerli_q, gecerli_d;
  logic [PS_BIT-1:0]     hedef_q, hedef_d;

  logic [SATIR_BIT-1:0]  l_btb_idx, l_bht_idx, g_btb_idx, g_bht_idx;
  logic                  l_hit, l_taken;
  logic                  unused_lsb;

  // Lookup side reads only registered state, so same-cycle training is invisible to it.
  assign l_btb_idx = bp.ps_i[SATIR_BIT:1];
  assign l_bht_idx = bp.ps_i[SATIR_BIT:1] ^ ghr_q;
  assign l_hit     = btb_gecerli_q[l_btb_idx] &&
                     (btb_etiket_q[l_btb_idx] == bp.ps_i[PS_BIT-1:SATIR_BIT+1]);
  assign l_taken   = bp.ps_gecerli_i && l_hit && bht_q[l_bht_idx][1];

  assign g_btb_idx = bp.g2_ps_i[SATIR_BIT:1];
  assign g_bht_idx = bp.g2_ps_i[SATIR_BIT:1] ^ ghr_q;

  // Bit 0 of a PC never selects anything: entries are halfword aligned.
  assign unused_lsb = bp.ps_i[0] ^ bp.g2_ps_i[0];

  assign bp.ongoru_atladi_o   = atladi_q;
  assign bp.ongoru_hedef_ps_o = hedef_q;
  assign bp.ongoru_gecerli_o  = gecerli_q;
  assign bp.hatali_sayac_o    = sayac_q;

  // Next-state: prediction outputs (flush > stall > lookup) and table training.
  always_comb begin
    bht_d         = bht_q;
    btb_gecerli_d = btb_gecerli_q;
    btb_etiket_d  = btb_etiket_q;
    btb_hedef_d   = btb_hedef_q;
    ghr_d         = ghr_q;
    sayac_d       = sayac_q;
    atladi_d      = atladi_q;
    gecerli_d     = gecerli_q;
    hedef_d       = hedef_q;

    if (bp.bosalt_i) begin
      atladi_d  = 1'b0;
      gecerli_d = 1'b0;
      hedef_d   = '0;
    end else if (!bp.duraklat_i) begin
      gecerli_d = bp.ps_gecerli_i;
      atladi_d  = l_taken;
      hedef_d   = l_taken ? btb_hedef_q[l_btb_idx] : '0;
    end

    if (bp.g2_guncelle_i) begin
      if (bp.g2_atladi_i) begin
        if (bht_q[g_bht_idx] != 2'b11) bht_d[g_bht_idx] = bht_q[g_bht_idx] + 2'd1;
        btb_gecerli_d[g_btb_idx] = 1'b1;
        btb_etiket_d[g_btb_idx]  = bp.g2_ps_i[PS_BIT-1:SATIR_BIT+1];
        btb_hedef_d[g_btb_idx]   = bp.g2_hedef_ps_i;
      end else begin
        if (bht_q[g_bht_idx] != 2'b00) bht_d[g_bht_idx] = bht_q[g_bht_idx] - 2'd1;
      end
      ghr_d = {ghr_q[GGT_BIT-2:0], bp.g2_atladi_i};
      if (bp.g2_hatali_tahmin_i) sayac_d = sayac_q + 32'd1;
    end
  end

  // State registers; async reset puts every counter at weakly-not-taken.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < SATIR; i++) begin
        bht_q[i]         <= 2'b01;
        btb_gecerli_q[i] <= 1'b0;
        btb_etiket_q[i]  <= '0;
        btb_hedef_q[i]   <= '0;
      end
      ghr_q     <= '0;
      sayac_q   <= '0;
      atladi_q  <= 1'b0;
      gecerli_q <= 1'b0;
      hedef_q   <= '0;
    end else begin
      bht_q         <= bht_d;
      btb_gecerli_q <= btb_gecerli_d;
      btb_etiket_q  <= btb_etiket_d;
      btb_hedef_q   <= btb_hedef_d;
      ghr_q         <= ghr_d;
      sayac_q       <= sayac_d;
      atladi_q      <= atladi_d;
      gecerli_q     <= gecerli_d;
      hedef_q       <= hedef_d;
    end
  end

endmodule

// File: tb/tb_dallanma_ongorucu.sv
// Self-checking bench for dallanma_ongorucu: directed scenarios then random
// traffic, all compared against a behavioural gshare model.
module tb_dallanma_ongorucu;

  logic clk_i = 1'b0;
  logic rstn_i;
  always #5 clk_i = ~clk_i;

  dallanma_ongorucu_if bp ();

  dallanma_ongorucu #(.PS_BIT(32), .SATIR_BIT(5), .GGT_BIT(5)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bp     (bp)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: BTB stores the whole branch PC, tag match compares PC/64.
  int          m_bht [32];
  bit          m_gec [32];
  logic [31:0] m_pc  [32];
  logic [31:0] m_hdf [32];
  int          m_ghr;
  logic [31:0] m_cnt;
  logic        e_gec, e_atl;
  logic [31:0] e_hdf;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_bht[i] = 1;
      m_gec[i] = 0;
      m_pc[i]  = 0;
      m_hdf[i] = 0;
    end
    m_ghr = 0;
    m_cnt = 0;
    e_gec = 0;
    e_atl = 0;
    e_hdf = 0;
  endtask

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    checks++;
    assert (gozlenen === beklenen)
      else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", etiket, gozlenen, beklenen);
      end
  endtask

  task automatic model_step(input logic [31:0] ps, input bit psg, dur, bos,
                            input bit gun, input logic [31:0] gps, ghdf, input bit gat, ghat);
    int li, lj, gi, gj;
    bit hit;
    li = int'((ps / 2) % 32);
    lj = li ^ m_ghr;
    gi = int'((gps / 2) % 32);
    gj = gi ^ m_ghr;
    if (bos) begin
      e_gec = 0; e_atl = 0; e_hdf = 0;
    end else if (!dur) begin
      hit   = m_gec[li] && ((m_pc[li] / 64) == (ps / 64));
      e_gec = psg;
      e_atl = psg && hit && (m_bht[lj] >= 2);
      e_hdf = e_atl ? m_hdf[li] : 32'd0;
    end
    if (gun) begin
      if (gat) begin
        m_bht[gj] = (m_bht[gj] == 3) ? 3 : m_bht[gj] + 1;
        m_gec[gi] = 1;
        m_pc[gi]  = gps;
        m_hdf[gi] = ghdf;
      end else begin
        m_bht[gj] = (m_bht[gj] == 0) ? 0 : m_bht[gj] - 1;
      end
      m_ghr = ((m_ghr * 2) + int'(gat)) % 32;
      if (ghat) m_cnt = m_cnt + 32'd1;
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare 1ns later.
  task automatic adim(input logic [31:0] ps, input bit psg, dur, bos,
                      input bit gun, input logic [31:0] gps, ghdf, input bit gat, ghat);
    bp.ps_i = ps; bp.ps_gecerli_i = psg; bp.duraklat_i = dur; bp.bosalt_i = bos;
    bp.g2_guncelle_i = gun; bp.g2_ps_i = gps; bp.g2_hedef_ps_i = ghdf;
    bp.g2_atladi_i = gat; bp.g2_hatali_tahmin_i = ghat;
    @(posedge clk_i);
    model_step(ps, psg, dur, bos, gun, gps, ghdf, gat, ghat);
    #1;
    kontrol("gecerli", {31'b0, bp.ongoru_gecerli_o}, {31'b0, e_gec});
    kontrol("atladi",  {31'b0, bp.ongoru_atladi_o},  {31'b0, e_atl});
    kontrol("hedef",   bp.ongoru_hedef_ps_o, e_hdf);
    kontrol("sayac",   bp.hatali_sayac_o, m_cnt);
  endtask

  task automatic bos_adim();
    adim(32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
  endtask

  logic [31:0] pc_havuz [6];
  logic        tut_gec, tut_atl;
  logic [31:0] tut_hdf;

  initial begin
    pc_havuz[0] = 32'h8000_0010; pc_havuz[1] = 32'h8000_0050;
    pc_havuz[2] = 32'h8000_0020; pc_havuz[3] = 32'h8000_1010;
    pc_havuz[4] = 32'h8000_0012; pc_havuz[5] = 32'h8000_003E;

    rstn_i = 1'b0;
    bp.ps_i = '0; bp.ps_gecerli_i = 0; bp.duraklat_i = 0; bp.bosalt_i = 0;
    bp.g2_guncelle_i = 0; bp.g2_ps_i = '0; bp.g2_hedef_ps_i = '0;
    bp.g2_atladi_i = 0; bp.g2_hatali_tahmin_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    kontrol("rst_gecerli", {31'b0, bp.ongoru_gecerli_o}, 32'd0);
    kontrol("rst_atladi",  {31'b0, bp.ongoru_atladi_o},  32'd0);
    kontrol("rst_hedef",   bp.ongoru_hedef_ps_o, 32'd0);
    kontrol("rst_sayac",   bp.hatali_sayac_o, 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;

    // Cold lookup: valid, not taken.
    adim(32'h8000_0000, 1, 0, 0, 0, 0, 0, 0, 0);
    kontrol("soguk_gecerli", {31'b0, bp.ongoru_gecerli_o}, 32'd1);
    kontrol("soguk_atladi",  {31'b0, bp.ongoru_atladi_o},  32'd0);
    kontrol("soguk_hedef",   bp.ongoru_hedef_ps_o, 32'd0);

    // Six taken trainings walk the history to 5'b11111.
    repeat (6) adim(0, 0, 0, 0, 1, 32'h8000_0010, 32'h8000_0100, 1, 0);
    adim(32'h8000_0010, 1, 0, 0, 0, 0, 0, 0, 0);
    kontrol("egitim_atladi", {31'b0, bp.ongoru_atladi_o}, 32'd1);
    kontrol("egitim_hedef",  bp.ongoru_hedef_ps_o, 32'h8000_0100);

    // Saturate, then one not-taken moves history to 5'b11110.
    repeat (2) adim(0, 0, 0, 0, 1, 32'h8000_0010, 32'h8000_0100, 1, 0);
    adim(0, 0, 0, 0, 1, 32'h8000_0010, 32'h8000_0100, 0, 0);
    adim(32'h8000_0010, 1, 0, 0, 0, 0, 0, 0, 0);
    kontrol("ghr_atladi",  {31'b0, bp.ongoru_atladi_o}, 32'd0);
    kontrol("ghr_gecerli", {31'b0, bp.ongoru_gecerli_o}, 32'd1);

    // Aliasing: same BTB slot, different tag evicts the old branch.
    adim(0, 0, 0, 0, 1, 32'h8000_0050, 32'h8000_0500, 1, 0);
    adim(32'h8000_0010, 1, 0, 0, 0, 0, 0, 0, 0);
    kontrol("alias_atladi", {31'b0, bp.ongoru_atladi_o}, 32'd0);
    kontrol("alias_hedef",  bp.ongoru_hedef_ps_o, 32'd0);

    // Stall holds outputs while training continues; flush beats stall.
    adim(32'h8000_0050, 1, 0, 0, 0, 0, 0, 0, 0);
    tut_gec = bp.ongoru_gecerli_o; tut_atl = bp.ongoru_atladi_o; tut_hdf = bp.ongoru_hedef_ps_o;
    adim(32'h8000_0012, 0, 1, 0, 1, 32'h8000_0020, 32'h8000_0200, 1, 0);
    kontrol("durak_gecerli", {31'b0, bp.ongoru_gecerli_o}, {31'b0, tut_gec});
    kontrol("durak_atladi",  {31'b0, bp.ongoru_atladi_o},  {31'b0, tut_atl});
    kontrol("durak_hedef",   bp.ongoru_hedef_ps_o, tut_hdf);
    adim(32'h8000_0020, 1, 1, 1, 1, 32'h8000_0020, 32'h8000_0200, 1, 0);
    kontrol("bosalt_gecerli", {31'b0, bp.ongoru_gecerli_o}, 32'd0);
    adim(32'h8000_0020, 1, 0, 0, 0, 0, 0, 0, 0);
    kontrol("durak_egitim_hedef", bp.ongoru_hedef_ps_o, e_atl ? 32'h8000_0200 : 32'd0);

    // Misprediction counter.
    repeat (3) adim(0, 0, 0, 0, 1, 32'h8000_0030, 32'h8000_0300, 0, 1);
    adim(0, 0, 0, 0, 1, 32'h8000_0030, 32'h8000_0300, 0, 0);
    kontrol("sayac_uc", bp.hatali_sayac_o, 32'd3);

    force dut.sayac_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    bos_adim();
    release dut.sayac_q;
    adim(0, 0, 0, 0, 1, 32'h8000_0030, 32'h8000_0300, 1, 1);
    kontrol("sayac_sarma", bp.hatali_sayac_o, 32'd0);

    // Random traffic over a small PC pool to provoke hits, aliasing and history effects.
    for (int n = 0; n < 400; n++) begin
      adim(pc_havuz[$urandom_range(0, 5)], 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)), pc_havuz[$urandom_range(0, 5)],
           32'h9000_0000 | ($urandom & 32'h0000_FFFE),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
    end

    // Asynchronous reset mid-stream clears outputs without waiting for an edge.
    #2;
    rstn_i = 1'b0;
    #1;
    kontrol("async_gecerli", {31'b0, bp.ongoru_gecerli_o}, 32'd0);
    kontrol("async_atladi",  {31'b0, bp.ongoru_atladi_o},  32'd0);
    kontrol("async_hedef",   bp.ongoru_hedef_ps_o, 32'd0);
    kontrol("async_sayac",   bp.hatali_sayac_o, 32'd0);
    model_reset();
    @(negedge clk_i);
    rstn_i = 1'b1;
    adim(32'h8000_0010, 1, 0, 0, 0, 0, 0, 0, 0);
    kontrol("rst_sonra_atladi",  {31'b0, bp.ongoru_atladi_o},  32'd0);
    kontrol("rst_sonra_gecerli", {31'b0, bp.ongoru_gecerli_o}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
